crc_serial_scheduler: RTL and testbench

//  Shares one serial LFSR_CRC engine among NUM_REQ parallel-byte requesters.

---
 rtl/crc_serial_scheduler.sv | 229 ++++++++++++++++++++++
 tb/tb_crc_serial_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_serial_scheduler.sv
// Round-robin scheduler sharing one serial CRC engine among NUM_REQ byte requesters.
// Bytes are shifted out LSB-first, the CRC is shifted back in, and the engine is cleared after every operation.
`timescale 1ns/1ps
module crc_serial_scheduler #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CRC_WIDTH  = 8,
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned CLR_CYCLES = 2
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]            GNT,
  output logic                          BUSY,
  output logic                          DONE,
  output logic [ID_WIDTH-1:0]           DONE_ID,
  output logic [CRC_WIDTH-1:0]          CRC_OUT,
  output logic                          ERR,
  output logic                          ENG_DATA,
  output logic                          ENG_ACTIVE,
  output logic                          ENG_RST_N,
  input  logic                          ENG_CRC,
  input  logic                          ENG_VALID
);

  localparam int unsigned CNT_A   = (TIMEOUT > DATA_WIDTH) ? TIMEOUT : DATA_WIDTH;
  localparam int unsigned CNT_B   = (CRC_WIDTH > CLR_CYCLES) ? CRC_WIDTH : CLR_CYCLES;
  localparam int unsigned CNT_MAX = (CNT_A > CNT_B) ? CNT_A : CNT_B;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_SHIFT,
    S_WAIT_V,
    S_COLLECT,
    S_RESP
  } state_t;

  state_t                 r_state, w_state_n;
  logic [CNT_W-1:0]       r_cnt, w_cnt_n;
  logic [ID_WIDTH-1:0]    r_ptr, w_ptr_n;
  logic [ID_WIDTH-1:0]    r_id, w_id_n;
  logic [DATA_WIDTH-1:0]  r_byte, w_byte_n;
  logic [CRC_WIDTH-2:0]   r_crc_sh, w_crc_sh_n;
  logic [NUM_REQ-1:0]     r_gnt, w_gnt_n;
  logic                   r_busy, w_busy_n;
  logic                   r_done, w_done_n;
  logic                   r_err, w_err_n;
  logic                   r_eng_data, w_eng_data_n;
  logic                   r_eng_active, w_eng_active_n;
  logic                   r_eng_rst_n, w_eng_rst_n_n;
  logic [CRC_WIDTH-1:0]   r_crc_out, w_crc_out_n;
  logic [ID_WIDTH-1:0]    r_done_id, w_done_id_n;

  logic                   w_any;
  logic [ID_WIDTH-1:0]    w_sel;
  logic [NUM_REQ-1:0]     w_sel_oh;
  logic [DATA_WIDTH-1:0]  w_sel_byte;

  // Rotating priority: indices above the pointer first, then wrap to 0..ptr.
  always_comb begin
    w_any      = 1'b0;
    w_sel      = '0;
    w_sel_oh   = '0;
    w_sel_byte = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!w_any && REQ[i] && (i > 32'(r_ptr))) begin
        w_any = 1'b1;
        w_sel = ID_WIDTH'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!w_any && REQ[i] && (i <= 32'(r_ptr))) begin
        w_any = 1'b1;
        w_sel = ID_WIDTH'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_any && (ID_WIDTH'(i) == w_sel)) begin
        w_sel_oh[i] = 1'b1;
        w_sel_byte  = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Outputs are computed one cycle ahead so every port comes straight from a flop.
  always_comb begin
    w_state_n      = r_state;
    w_cnt_n        = r_cnt;
    w_ptr_n        = r_ptr;
    w_id_n         = r_id;
    w_byte_n       = r_byte;
    w_crc_sh_n     = r_crc_sh;
    w_gnt_n        = '0;
    w_done_n       = 1'b0;
    w_err_n        = 1'b0;
    w_eng_data_n   = 1'b0;
    w_eng_active_n = 1'b0;
    w_eng_rst_n_n  = 1'b1;
    w_crc_out_n    = r_crc_out;
    w_done_id_n    = r_done_id;
    case (r_state)
      S_CLEAR: begin
        if (r_cnt == CNT_W'(CLR_CYCLES - 1)) begin
          w_state_n = S_IDLE;
          w_cnt_n   = '0;
        end else begin
          w_eng_rst_n_n = 1'b0;
          w_cnt_n       = r_cnt + CNT_W'(1);
        end
      end
      S_IDLE: begin
        if (w_any) begin
          w_gnt_n        = w_sel_oh;
          w_id_n         = w_sel;
          w_ptr_n        = w_sel;
          w_eng_data_n   = w_sel_byte[0];
          w_byte_n       = w_sel_byte >> 1;
          w_eng_active_n = 1'b1;
          w_cnt_n        = '0;
          w_state_n      = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_cnt == CNT_W'(DATA_WIDTH - 1)) begin
          w_cnt_n   = '0;
          w_state_n = S_WAIT_V;
        end else begin
          w_eng_active_n = 1'b1;
          w_eng_data_n   = r_byte[0];
          w_byte_n       = r_byte >> 1;
          w_cnt_n        = r_cnt + CNT_W'(1);
        end
      end
      S_WAIT_V: begin
        if (ENG_VALID) begin
          w_crc_sh_n = {ENG_CRC, r_crc_sh[CRC_WIDTH-2:1]};
          w_cnt_n    = CNT_W'(1);
          w_state_n  = S_COLLECT;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_err_n       = 1'b1;
          w_eng_rst_n_n = 1'b0;
          w_cnt_n       = '0;
          w_state_n     = S_CLEAR;
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      S_COLLECT: begin
        if (!ENG_VALID) begin
          w_err_n       = 1'b1;
          w_eng_rst_n_n = 1'b0;
          w_cnt_n       = '0;
          w_state_n     = S_CLEAR;
        end else if (r_cnt == CNT_W'(CRC_WIDTH - 1)) begin
          w_crc_out_n = {ENG_CRC, r_crc_sh};
          w_done_id_n = r_id;
          w_done_n    = 1'b1;
          w_state_n   = S_RESP;
        end else begin
          w_crc_sh_n = {ENG_CRC, r_crc_sh[CRC_WIDTH-2:1]};
          w_cnt_n    = r_cnt + CNT_W'(1);
        end
      end
      S_RESP: begin
        w_eng_rst_n_n = 1'b0;
        w_cnt_n       = '0;
        w_state_n     = S_CLEAR;
      end
      default: begin
        w_eng_rst_n_n = 1'b0;
        w_cnt_n       = '0;
        w_state_n     = S_CLEAR;
      end
    endcase
    w_busy_n = (w_state_n != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= S_CLEAR;
      r_cnt        <= '0;
      r_ptr        <= ID_WIDTH'(NUM_REQ - 1);
      r_id         <= '0;
      r_byte       <= '0;
      r_crc_sh     <= '0;
      r_gnt        <= '0;
      r_busy       <= 1'b1;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_eng_data   <= 1'b0;
      r_eng_active <= 1'b0;
      r_eng_rst_n  <= 1'b0;
      r_crc_out    <= '0;
      r_done_id    <= '0;
    end else begin
      r_state      <= w_state_n;
      r_cnt        <= w_cnt_n;
      r_ptr        <= w_ptr_n;
      r_id         <= w_id_n;
      r_byte       <= w_byte_n;
      r_crc_sh     <= w_crc_sh_n;
      r_gnt        <= w_gnt_n;
      r_busy       <= w_busy_n;
      r_done       <= w_done_n;
      r_err        <= w_err_n;
      r_eng_data   <= w_eng_data_n;
      r_eng_active <= w_eng_active_n;
      r_eng_rst_n  <= w_eng_rst_n_n;
      r_crc_out    <= w_crc_out_n;
      r_done_id    <= w_done_id_n;
    end
  end

  assign GNT        = r_gnt;
  assign BUSY       = r_busy;
  assign DONE       = r_done;
  assign DONE_ID    = r_done_id;
  assign CRC_OUT    = r_crc_out;
  assign ERR        = r_err;
  assign ENG_DATA   = r_eng_data;
  assign ENG_ACTIVE = r_eng_active;
  assign ENG_RST_N  = r_eng_rst_n;

endmodule

// File: tb/tb_crc_serial_scheduler.sv
// Bench for crc_serial_scheduler: behavioural serial CRC-8 engine plus a scoreboard of expected responses.
`timescale 1ns/1ps
module tb_crc_serial_scheduler;

  localparam int unsigned ENG_DELAY = 3;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  REQ = '0;
  logic [31:0] REQ_DATA = '0;
  logic [3:0]  GNT;
  logic        BUSY, DONE, ERR, ENG_DATA, ENG_ACTIVE, ENG_RST_N;
  logic [1:0]  DONE_ID;
  logic [7:0]  CRC_OUT;
  logic        ENG_CRC = 1'b0;
  logic        ENG_VALID = 1'b0;

  always #5 CLK = ~CLK;

  crc_serial_scheduler #(
    .NUM_REQ(4), .ID_WIDTH(2), .DATA_WIDTH(8), .CRC_WIDTH(8), .TIMEOUT(16), .CLR_CYCLES(2)
  ) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_DATA(REQ_DATA), .GNT(GNT), .BUSY(BUSY),
    .DONE(DONE), .DONE_ID(DONE_ID), .CRC_OUT(CRC_OUT), .ERR(ERR), .ENG_DATA(ENG_DATA),
    .ENG_ACTIVE(ENG_ACTIVE), .ENG_RST_N(ENG_RST_N), .ENG_CRC(ENG_CRC), .ENG_VALID(ENG_VALID)
  );

  int          n_assert = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  int unsigned fall_cyc = 0;
  int unsigned res_cyc = 0;
  logic        prev_act = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  // CRC-8, polynomial 0x07, zero seed, message bits fed in arrival order.
  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
  endfunction

  function automatic logic [7:0] crc8(input logic [7:0] d);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = crc_step(c, d[i]);
    return c;
  endfunction

  // Engine modes: 0 fixed stub value, 1 real CRC, 2 never valid, 3 valid drops after 4 bits.
  logic [1:0] eng_mode = 2'd0;
  logic [7:0] stub_val = 8'h00;
  logic [1:0] e_state = 2'd0;
  logic [3:0] e_dly = '0;
  logic [3:0] e_bit = '0;
  logic [4:0] e_nact = '0;
  logic [7:0] e_sh = '0, e_lfsr = '0, e_out = '0;
  logic [7:0] e_last_byte = '0;
  logic [4:0] e_last_cnt = '0;

  always @(posedge CLK) begin
    if (ENG_RST_N === 1'b0) begin
      e_state <= 2'd0; e_nact <= '0; e_sh <= '0; e_lfsr <= '0;
      ENG_VALID <= 1'b0; ENG_CRC <= 1'b0;
    end else begin
      case (e_state)
        2'd0: if (ENG_ACTIVE === 1'b1) begin
                e_sh   <= {ENG_DATA, e_sh[7:1]};
                e_lfsr <= crc_step(e_lfsr, ENG_DATA);
                e_nact <= e_nact + 5'd1;
              end else if (e_nact != 0) begin
                e_last_byte <= e_sh; e_last_cnt <= e_nact;
                e_dly <= '0; e_state <= 2'd1;
              end
        2'd1: if (e_dly == 4'(ENG_DELAY - 1)) begin
                if (eng_mode == 2'd2) e_state <= 2'd3;
                else begin
                  e_out     <= (eng_mode == 2'd1) ? e_lfsr : stub_val;
                  ENG_CRC   <= (eng_mode == 2'd1) ? e_lfsr[0] : stub_val[0];
                  ENG_VALID <= 1'b1;
                  e_bit     <= 4'd1;
                  e_state   <= 2'd2;
                end
              end else e_dly <= e_dly + 4'd1;
        2'd2: if (e_bit == ((eng_mode == 2'd3) ? 4'd4 : 4'd8)) begin
                ENG_VALID <= 1'b0; ENG_CRC <= 1'b0; e_state <= 2'd3;
              end else begin
                ENG_CRC <= e_out[e_bit[2:0]];
                e_bit   <= e_bit + 4'd1;
              end
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (prev_act && ENG_ACTIVE === 1'b0) fall_cyc = cyc;
    prev_act = (ENG_ACTIVE === 1'b1);
    if (RST === 1'b0) begin
      check("gnt_onehot0", {31'b0, $onehot0(GNT)}, 32'd1);
      check("done_err_excl", {31'b0, DONE & ERR}, 32'd0);
    end
  end

  typedef struct {
    logic       is_err;
    logic [1:0] id;
    logic [7:0] crc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model_crc = '0;

  task automatic push_done(input logic [1:0] id, input logic [7:0] crc);
    exp_t e;
    e.is_err = 1'b0; e.id = id; e.crc = crc;
    sb.push_back(e);
    model_crc = crc;
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1; e.id = '0; e.crc = model_crc;
    sb.push_back(e);
  endtask

  task automatic wait_gnt(input string tag, output logic [3:0] g);
    int n = 0;
    while (GNT === 4'b0 && n < 60) begin @(negedge CLK); n++; end
    g = GNT;
    check({tag, "_gnt_seen"}, {31'b0, (GNT !== 4'b0)}, 32'd1);
  endtask

  task automatic wait_result(input string tag);
    int   n = 0;
    exp_t e;
    @(negedge CLK);
    while (DONE !== 1'b1 && ERR !== 1'b1 && n < 200) begin @(negedge CLK); n++; end
    res_cyc = cyc;
    check({tag, "_resp_seen"}, {31'b0, (DONE === 1'b1 || ERR === 1'b1)}, 32'd1);
    check({tag, "_sb_nonempty"}, {31'b0, (sb.size() != 0)}, 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_err"}, {31'b0, ERR}, {31'b0, e.is_err});
      check({tag, "_done"}, {31'b0, DONE}, {31'b0, !e.is_err});
      check({tag, "_crc"}, {24'b0, CRC_OUT}, {24'b0, e.crc});
      if (!e.is_err) check({tag, "_id"}, {30'b0, DONE_ID}, {30'b0, e.id});
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; REQ = '0;
    repeat (3) @(negedge CLK);
    check("rst_eng_rst_n", {31'b0, ENG_RST_N}, 32'd0);
    check("rst_gnt", {28'b0, GNT}, 32'd0);
    check("rst_done", {31'b0, DONE}, 32'd0);
    check("rst_err", {31'b0, ERR}, 32'd0);
    check("rst_busy", {31'b0, BUSY}, 32'd1);
    check("rst_active", {31'b0, ENG_ACTIVE}, 32'd0);
    check("rst_crc_out", {24'b0, CRC_OUT}, 32'd0);
    check("rst_done_id", {30'b0, DONE_ID}, 32'd0);
    RST = 1'b0;
    model_crc = '0;
    @(negedge CLK);
    check("rel_eng_rst_n_low", {31'b0, ENG_RST_N}, 32'd0);
    check("rel_busy_clear", {31'b0, BUSY}, 32'd1);
    @(negedge CLK);
    check("rel_eng_rst_n_high", {31'b0, ENG_RST_N}, 32'd1);
    check("rel_idle_busy", {31'b0, BUSY}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] g;
    logic [1:0] id;
    logic [7:0] golden [10];
    logic       seen;
    golden = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'h3C, 8'hA5, 8'h5A, 8'h7E, 8'hC3, 8'h96};

    // 1: reset
    do_reset();

    // 2: single request, fixed stub response
    eng_mode = 2'd0; stub_val = 8'hA5;
    REQ_DATA = 32'h0000_3C00; REQ = 4'b0010;
    wait_gnt("t2", g);
    check("t2_gnt", {28'b0, g}, 32'h2);
    REQ = '0;
    push_done(2'd1, 8'hA5);
    @(negedge CLK);
    check("t2_gnt_pulse", {28'b0, GNT}, 32'd0);
    wait_result("t2");
    check("t2_serial_byte", {24'b0, e_last_byte}, 32'h3C);
    check("t2_active_cycles", {27'b0, e_last_cnt}, 32'd8);
    @(negedge CLK);
    check("t2_done_pulse", {31'b0, DONE}, 32'd0);

    // 3: round robin with every request held
    do_reset();
    eng_mode = 2'd1;
    REQ_DATA = 32'h4433_2211; REQ = 4'hF;
    for (int k = 0; k < 5; k++) begin
      id = 2'(k % 4);
      wait_gnt("t3", g);
      check("t3_gnt_order", {28'b0, g}, 32'(1) << id);
      if (k == 4) REQ = '0;
      push_done(id, crc8(REQ_DATA[id*8 +: 8]));
      wait_result("t3");
    end

    // 4: engine never raises VALID
    eng_mode = 2'd2;
    REQ_DATA = 32'h005A_0000; REQ = 4'b0100;
    wait_gnt("t4", g);
    check("t4_gnt", {28'b0, g}, 32'h4);
    REQ = '0;
    push_err();
    wait_result("t4");
    check("t4_timeout_latency", res_cyc - fall_cyc, 32'd16);
    check("t4_clr0", {31'b0, ENG_RST_N}, 32'd0);
    @(negedge CLK);
    check("t4_clr1", {31'b0, ENG_RST_N}, 32'd0);
    check("t4_err_pulse", {31'b0, ERR}, 32'd0);
    @(negedge CLK);
    check("t4_clr_done", {31'b0, ENG_RST_N}, 32'd1);
    check("t4_idle", {31'b0, BUSY}, 32'd0);
    eng_mode = 2'd0; stub_val = 8'h96;
    REQ_DATA = 32'hC300_0000; REQ = 4'b1000;
    wait_gnt("t4n", g);
    check("t4n_gnt", {28'b0, g}, 32'h8);
    REQ = '0;
    push_done(2'd3, 8'h96);
    wait_result("t4n");

    // 5: VALID drops out mid-collection
    eng_mode = 2'd3; stub_val = 8'h3E;
    REQ_DATA = 32'h0000_0077; REQ = 4'b0001;
    wait_gnt("t5", g);
    check("t5_gnt", {28'b0, g}, 32'h1);
    REQ = '0;
    push_err();
    wait_result("t5");
    repeat (4) @(negedge CLK);
    check("t5_idle", {31'b0, BUSY}, 32'd0);

    // 6: real CRC over several bytes and requesters
    eng_mode = 2'd1;
    for (int k = 0; k < 10; k++) begin
      id = 2'(k % 4);
      REQ_DATA = '0;
      REQ_DATA[id*8 +: 8] = golden[k];
      REQ = 4'(1) << id;
      wait_gnt("t6", g);
      check("t6_gnt", {28'b0, g}, 32'(1) << id);
      REQ = '0;
      push_done(id, crc8(golden[k]));
      wait_result("t6");
    end

    // 6b: reset in the middle of SHIFT, then a clean operation
    REQ_DATA = 32'h00E1_0000; REQ = 4'b0100;
    wait_gnt("t6r", g);
    REQ = '0;
    repeat (3) @(negedge CLK);
    check("t6r_in_shift", {31'b0, ENG_ACTIVE}, 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    check("t6r_rst_active", {31'b0, ENG_ACTIVE}, 32'd0);
    check("t6r_rst_eng_rst_n", {31'b0, ENG_RST_N}, 32'd0);
    check("t6r_rst_busy", {31'b0, BUSY}, 32'd1);
    RST = 1'b0;
    model_crc = '0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge CLK);
      if (DONE === 1'b1 || ERR === 1'b1) seen = 1'b1;
    end
    check("t6r_no_resp", {31'b0, seen}, 32'd0);
    check("t6r_crc_cleared", {24'b0, CRC_OUT}, 32'd0);
    REQ_DATA = 32'h0000_5E00; REQ = 4'b0010;
    wait_gnt("t6c", g);
    check("t6c_gnt", {28'b0, g}, 32'h2);
    REQ = '0;
    push_done(2'd1, crc8(8'h5E));
    wait_result("t6c");

    check("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
